wf_rr_arbiter_40: RTL and testbench
===================================

WF_RR_ARBITER_40 -- requirements
Module: wf_rr_arbiter_40

Interface
REQ-001 The block SHALL have no parameters; the wavefront count is fixed at 40 and the ID width at 6.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_vec  input  40  bit i = 1 means wavefront i requests issue.
REQ-005 grant_ready  input  1  downstream (wfid one-hot decode/issue) accepts the offered grant this cycle.
REQ-006 release_valid  input  1  qualifies release_wfid.
REQ-007 release_wfid  input  6  wavefront whose busy bit is cleared.
REQ-008 grant_valid  output  1  a grant is offered; registered.
REQ-009 grant_wfid  output  6  offered wavefront ID, 0..39; registered.
REQ-010 busy_vec  output  40  bit i = 1 means wavefront i is granted and not yet released; registered.

Function
REQ-011 eligible SHALL equal req_vec AND NOT busy_vec.
REQ-012 A 6-bit pointer ptr (0..39) SHALL hold the last accepted wfid.
REQ-013 Selection SHALL take the first set eligible bit at index (ptr+1) mod 40, (ptr+2) mod 40, ..., ptr, wrapping from 39 to 0.
REQ-014 FSM states SHALL be IDLE (grant_valid=0) and OFFER (grant_valid=1).
REQ-015 In IDLE with eligible nonzero, the block SHALL load the selected index into grant_wfid and enter OFFER at the next edge; latency is 1 cycle from eligible to grant_valid.
REQ-016 In IDLE with eligible zero, the block SHALL remain in IDLE with grant_wfid unchanged.
REQ-017 In OFFER with grant_ready=0, grant_wfid and grant_valid SHALL hold stable; a grant is never retracted, even if its req_vec bit drops.
REQ-018 In OFFER with grant_ready=1, the accept SHALL set busy_vec[grant_wfid] and set ptr to grant_wfid at that edge.
REQ-019 On an accept, selection for the next offer SHALL use the accepted wfid as ptr and exclude it from eligible.
REQ-020 On an accept, if any wavefront remains eligible the block SHALL load the next selection and stay in OFFER (back-to-back, one grant per cycle); otherwise it SHALL go to IDLE.
REQ-021 release_valid=1 with release_wfid < 40 SHALL clear busy_vec[release_wfid] at the edge; the freed wavefront becomes eligible the following cycle.
REQ-022 release_wfid of 40..63 SHALL be ignored.
REQ-023 A release and an accept of the same wfid in the same cycle SHALL leave the busy bit set (accept wins).
REQ-024 A release of a non-busy wavefront SHALL have no effect.
REQ-025 grant_ready while in IDLE SHALL be ignored.

Reset
REQ-026 When rst=0, the block SHALL immediately and asynchronously force: state IDLE, grant_valid=0, grant_wfid=0, busy_vec=0, ptr=39, so the first search after reset starts at index 0.
REQ-027 A reset asserted during OFFER SHALL abandon the offer; no busy bit is set for it.

Verification
REQ-028 Reset, then req_vec bits 5 and 9 set and grant_ready=1 held -> next cycle grant_wfid=5; next cycle grant_wfid=9; then grant_valid=0 and busy_vec=40'h0000000220.
REQ-029 Wrap-around: ptr=38, req_vec bits 2 and 39 set -> grants 39 then 2, in that order.
REQ-030 Back-pressure: grant_ready=0 for 5 cycles during an offer of wfid 7 while req_vec[7] drops -> grant_valid=1 and grant_wfid=7 stable throughout; the accept on cycle 6 sets busy_vec[7].
REQ-031 Same-cycle accept of wfid 5 and release_wfid=5 -> busy_vec[5]=1; a release of 5 the next cycle -> busy_vec[5]=0, and wfid 5 is grantable again the cycle after.
REQ-032 release_valid=1 with release_wfid=45 -> busy_vec unchanged.
REQ-033 rst=0 mid-OFFER -> grant_valid=0, grant_wfid=0, busy_vec=0 before the next clock edge; after release, the first grant searches from index 0.

Source files
------------

// File: rtl/wf_rr_arbiter_40.sv
// wf_rr_arbiter_40: round-robin issue arbiter over 40 wavefronts with busy tracking.
// One registered grant offer at a time; accepted wavefronts stay busy until released.
module wf_rr_arbiter_40 (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] req_vec,
  input  logic        grant_ready,
  input  logic        release_valid,
  input  logic [5:0]  release_wfid,
  output logic        grant_valid,
  output logic [5:0]  grant_wfid,
  output logic [39:0] busy_vec
);
  typedef enum logic {IDLE, OFFER} state_e;
  state_e      state_q;
  logic [5:0]  ptr_q, grant_wfid_q, sel, start;
  logic [39:0] busy_q, busy_d, elig, acc_bit, rel_bit;
  logic [6:0]  s;
  logic        accept, any;
  // Selection uses pre-release busy bits so a freed wavefront waits one cycle.
  always_comb begin
    accept  = (state_q == OFFER) && grant_ready;
    acc_bit = accept ? (40'd1 << grant_wfid_q) : '0;
    rel_bit = (release_valid && release_wfid < 6'd40) ? (40'd1 << release_wfid) : '0;
    busy_d  = (busy_q & ~rel_bit) | acc_bit;
    elig    = req_vec & ~busy_q & ~acc_bit;
    any     = |elig;
    start   = accept ? grant_wfid_q : ptr_q;
    sel     = '0;
    s       = '0;
    for (int k = 40; k >= 1; k--) begin
      s = {1'b0, start} + 7'(k);
      s = (s >= 7'd40) ? s - 7'd40 : s;
      if (elig[s[5:0]]) sel = s[5:0];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_wfid_q <= '0;
      busy_q       <= '0;
      ptr_q        <= 6'd39;
    end else begin
      busy_q <= busy_d;
      if (accept) ptr_q <= grant_wfid_q;
      if (state_q == IDLE || grant_ready) begin
        if (any) begin
          grant_wfid_q <= sel;
          state_q      <= OFFER;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end
  assign grant_valid = (state_q == OFFER);
  assign grant_wfid  = grant_wfid_q;
  assign busy_vec    = busy_q;
endmodule

// File: tb/tb_wf_rr_arbiter_40.sv
// tb_wf_rr_arbiter_40: directed boundary scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_wf_rr_arbiter_40;
  logic        clk = 0;
  logic        rst = 0;
  logic [39:0] req_vec = '0;
  logic        grant_ready = 0;
  logic        release_valid = 0;
  logic [5:0]  release_wfid = '0;
  logic        grant_valid;
  logic [5:0]  grant_wfid;
  logic [39:0] busy_vec;

  int n_chk = 0;
  int n_fail = 0;

  bit [39:0] m_busy;
  int        m_ptr, m_wfid;
  bit        m_valid;

  wf_rr_arbiter_40 dut (
    .clk(clk), .rst(rst), .req_vec(req_vec), .grant_ready(grant_ready),
    .release_valid(release_valid), .release_wfid(release_wfid),
    .grant_valid(grant_valid), .grant_wfid(grant_wfid), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_ptr = 39; m_wfid = 0; m_valid = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 64'(grant_valid), 64'(m_valid));
    chk({tag, "_wfid"},  64'(grant_wfid),  64'(m_wfid));
    chk({tag, "_busy"},  64'(busy_vec),    64'(m_busy));
  endtask

  task automatic model_edge();
    bit [39:0] nb;
    bit        acc, found;
    int        start, pick, i, old;
    acc = m_valid && grant_ready;
    old = m_wfid;
    nb  = m_busy;
    if (release_valid && release_wfid < 40) nb[release_wfid] = 1'b0;
    if (acc) nb[old] = 1'b1;
    if (!m_valid || grant_ready) begin
      start = acc ? old : m_ptr;
      found = 0; pick = 0;
      for (int k = 1; k <= 40; k++) begin
        i = (start + k) % 40;
        if (!found && req_vec[i] && !m_busy[i] && !(acc && i == old)) begin
          found = 1; pick = i;
        end
      end
      m_valid = found;
      if (found) m_wfid = pick;
    end
    if (acc) m_ptr = old;
    m_busy = nb;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #2;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #1;
    model_reset();
    check_all("rst");
    req_vec = '0; grant_ready = 0; release_valid = 0; release_wfid = '0;
    #2 rst = 1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("por");
    #4 rst = 1;

    // Two requests with ready held: 5 then 9, then idle
    do_reset();
    req_vec = 40'h220; grant_ready = 1;
    step("s28a"); chk("s28_first", 64'(grant_wfid), 64'd5);
    step("s28b"); chk("s28_second", 64'(grant_wfid), 64'd9);
    step("s28c"); chk("s28_idle", 64'(grant_valid), 64'd0);
    chk("s28_busy", 64'(busy_vec), 64'h220);

    // Wrap-around from ptr=38
    do_reset();
    req_vec = 40'd1 << 38; grant_ready = 1;
    step("s29a"); step("s29b");
    release_valid = 1; release_wfid = 6'd38;
    req_vec = (40'd1 << 39) | (40'd1 << 2);
    step("s29c"); chk("s29_wrap1", 64'(grant_wfid), 64'd39);
    release_valid = 0;
    step("s29d"); chk("s29_wrap2", 64'(grant_wfid), 64'd2);

    // Back-pressure on wfid 7 while its request drops
    do_reset();
    req_vec = 40'd1 << 7; grant_ready = 0;
    step("s30a");
    req_vec = '0;
    for (int c = 0; c < 5; c++) begin
      step("s30hold");
      chk("s30_stable", 64'({grant_valid, grant_wfid}), 64'({1'b1, 6'd7}));
    end
    grant_ready = 1;
    step("s30acc"); chk("s30_busy7", 64'(busy_vec[7]), 64'd1);

    // Same-cycle accept and release: accept wins
    do_reset();
    req_vec = 40'd1 << 5; grant_ready = 1;
    step("s31a");
    release_valid = 1; release_wfid = 6'd5;
    step("s31b"); chk("s31_acc_wins", 64'(busy_vec[5]), 64'd1);
    step("s31c"); chk("s31_released", 64'(busy_vec[5]), 64'd0);
    release_valid = 0; grant_ready = 0;
    step("s31d"); chk("s31_regrant", 64'({grant_valid, grant_wfid}), 64'({1'b1, 6'd5}));

    // Out-of-range release ignored
    grant_ready = 1; req_vec = '0;
    step("s32a");
    release_valid = 1; release_wfid = 6'd45;
    step("s32b"); chk("s32_busy", 64'(busy_vec), 64'(40'd1 << 5));
    release_valid = 0;

    // Reset mid-offer, then search restarts at 0
    req_vec = 40'hff_0000_0000; grant_ready = 0;
    step("s33a");
    chk("s33_offer", 64'(grant_valid), 64'd1);
    do_reset();
    chk("s33_rst", 64'({grant_valid, grant_wfid, busy_vec}), 64'd0);
    req_vec = (40'd1 << 39) | 40'd1; grant_ready = 1;
    step("s33b"); chk("s33_from0", 64'(grant_wfid), 64'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_vec       = ($urandom_range(0, 3) == 0) ? '0 :
                      ({$urandom, $urandom} & {$urandom, $urandom});
      grant_ready   = $urandom_range(0, 3) != 0;
      release_valid = $urandom_range(0, 1) != 0;
      release_wfid  = 6'($urandom_range(0, 63));
      step("rnd");
      if (c == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
